// File: rtl/oam_dma_if.sv
// Signal bundle between the OAM DMA engine and its surroundings
// (CPU $4014 strobe, CPU-bus read port, PPU register write port).
interface oam_dma_if;
  logic        dma_sel;
  logic [7:0]  dma_page;
  logic [15:0] bus_addr;
  logic        bus_rden;
  logic [7:0]  bus_data_in;
  logic [2:0]  ppu_addr;
  logic [7:0]  ppu_data_out;
  logic        ppu_wren;
  logic        cpu_halt;
  logic        done;

  modport master (
    input  dma_sel, dma_page, bus_data_in,
    output bus_addr, bus_rden, ppu_addr, ppu_data_out, ppu_wren, cpu_halt, done
  );

  modport slave (
    output dma_sel, dma_page, bus_data_in,
    input  bus_addr, bus_rden, ppu_addr, ppu_data_out, ppu_wren, cpu_halt, done
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: on a $4014 write, halts the CPU and copies page $P00..$PFF
// into the PPU OAMDATA register, one byte per READ/WRITE cycle pair.
module oam_dma #(
  parameter int         NUM_BYTES = 256,
  parameter logic [2:0] OAM_REG   = 3'd4
) (
  input  logic     clk,
  input  logic     reset,
  oam_dma_if.master bus
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

  state_t     state_reg, state_next;
  logic       parity_reg;
  logic [7:0] idx_reg, idx_next;
  logic [7:0] page_reg, page_next;
  logic       done_reg, done_next;

  // Parity free-runs so reads always begin on an even CPU cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      parity_reg <= 1'b0;
      idx_reg    <= 8'd0;
      page_reg   <= 8'd0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      parity_reg <= ~parity_reg;
      idx_reg    <= idx_next;
      page_reg   <= page_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    page_next        = page_reg;
    done_next        = 1'b0;
    bus.bus_addr     = 16'h0000;
    bus.bus_rden     = 1'b0;
    bus.ppu_addr     = 3'd0;
    bus.ppu_data_out = 8'h00;
    bus.ppu_wren     = 1'b0;
    bus.cpu_halt     = (state_reg != IDLE);
    bus.done         = done_reg;

    case (state_reg)
      IDLE: begin
        if (bus.dma_sel) begin
          page_next  = bus.dma_page;
          idx_next   = 8'd0;
          state_next = HALT;
        end
      end
      HALT: begin
        state_next = parity_reg ? READ : ALIGN;
      end
      ALIGN: begin
        state_next = READ;
      end
      READ: begin
        bus.bus_addr = {page_reg, idx_reg};
        bus.bus_rden = 1'b1;
        state_next   = WRITE;
      end
      WRITE: begin
        // Read data arrives this cycle from the registered memory; pass it straight on.
        bus.ppu_wren     = 1'b1;
        bus.ppu_addr     = OAM_REG;
        bus.ppu_data_out = bus.bus_data_in;
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          idx_next   = idx_reg + 8'd1;
          state_next = READ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected OAM bytes and halt
// lengths; a negedge monitor pops and compares as the DUT produces them.
module tb_oam_dma;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  oam_dma_if ifc();

  oam_dma #(.NUM_BYTES(256), .OAM_REG(3'd4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         halt_q[$];
  logic [7:0] exp_page = 8'h00;
  logic [7:0] rd_exp = 8'h00;
  logic       first_rd = 1'b0;
  int         wr_seen = 0;
  int         halt_run = 0;
  logic       par_model;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] popped;

  // Page 2 holds i^A5; other pages are further xored with (page^2).
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ (a[15:8] ^ 8'h02);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk or posedge reset)
    if (reset) par_model <= 1'b0;
    else       par_model <= ~par_model;

  // Registered-read memory: data valid the cycle after bus_rden.
  always @(posedge clk)
    if (ifc.bus_rden) rd_data <= mem_val(ifc.bus_addr);
  assign ifc.bus_data_in = rd_data;

  always @(negedge clk) begin
    if (reset) begin
      halt_run = 0;
    end else begin
      chk("rd_wr_excl", {31'd0, ifc.bus_rden & ifc.ppu_wren}, 32'd0);
      if (ifc.bus_rden) begin
        if (first_rd) begin
          chk("first_read_parity", {31'd0, par_model}, 32'd0);
          first_rd = 1'b0;
        end
        chk("bus_addr", {16'd0, ifc.bus_addr}, {16'd0, exp_page, rd_exp});
        rd_exp = rd_exp + 8'd1;
      end else begin
        chk("bus_quiet", {16'd0, ifc.bus_addr}, 32'd0);
      end
      if (ifc.ppu_wren) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          popped = exp_q.pop_front();
          chk("ppu_write", {21'd0, ifc.ppu_addr, ifc.ppu_data_out}, {21'd0, 3'd4, popped});
        end
        wr_seen++;
      end else begin
        chk("ppu_quiet", {21'd0, ifc.ppu_addr, ifc.ppu_data_out}, 32'd0);
      end
      if (ifc.cpu_halt) begin
        halt_run++;
      end else if (halt_run > 0) begin
        chk("done_at_halt_fall", {31'd0, ifc.done}, 32'd1);
        if (halt_q.size() == 0) chk("unexpected_halt", halt_run, 32'd0);
        else                    chk("halt_len", halt_run, halt_q.pop_front());
        halt_run = 0;
      end else begin
        chk("done_idle", {31'd0, ifc.done}, 32'd0);
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return {1'b0, ifc.bus_addr, ifc.bus_rden, ifc.ppu_addr, ifc.ppu_data_out,
            ifc.ppu_wren, ifc.cpu_halt, ifc.done};
  endfunction

  // Called just after a negedge; dma_sel is sampled at the following posedge.
  task automatic start_xfer(input logic [7:0] page);
    halt_q.push_back(par_model == 1'b0 ? 513 : 514);
    for (int i = 0; i < 256; i++) exp_q.push_back(mem_val({page, 8'(i)}));
    exp_page     = page;
    rd_exp       = 8'h00;
    first_rd     = 1'b1;
    wr_seen      = 0;
    ifc.dma_sel  = 1'b1;
    ifc.dma_page = page;
    @(posedge clk);
    #1;
    ifc.dma_sel  = 1'b0;
    ifc.dma_page = 8'h00;
  endtask

  task automatic trigger(input logic [7:0] page, input logic want_par);
    @(negedge clk);
    if (par_model !== want_par) @(negedge clk);
    #1;
    start_xfer(page);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      #1;
      if (ifc.done) begin
        chk("write_count", wr_seen, 32'd256);
        chk("queue_drained", exp_q.size(), 32'd0);
        return;
      end
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_writes(input int target);
    for (int n = 0; n < 2000; n++) begin
      if (wr_seen >= target) return;
      @(negedge clk);
      #1;
    end
    chk("write_wait_timeout", wr_seen, target);
  endtask

  initial begin
    ifc.dma_sel  = 1'b0;
    ifc.dma_page = 8'h00;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("idle_outputs", all_outs(), 32'd0);
    end

    trigger(8'h02, 1'b0);
    wait_done();
    $display("xfer page=02 even trigger complete");

    trigger(8'h02, 1'b1);
    wait_done();
    $display("xfer page=02 odd trigger complete");

    trigger(8'h02, 1'b0);
    wait_writes(100);
    ifc.dma_sel  = 1'b1;
    ifc.dma_page = 8'h07;
    @(posedge clk);
    #1;
    ifc.dma_sel  = 1'b0;
    ifc.dma_page = 8'h00;
    wait_done();
    $display("xfer page=02 with ignored page=07 strobe complete");

    trigger(8'h02, 1'b0);
    wait_done();
    chk("b2b_gap_low", {31'd0, ifc.cpu_halt}, 32'd0);
    start_xfer(8'h03);
    @(negedge clk);
    #1;
    chk("b2b_halt_reasserts", {31'd0, ifc.cpu_halt}, 32'd1);
    wait_done();
    $display("xfer back-to-back page=03 complete");

    trigger(8'h02, 1'b0);
    wait_writes(38);
    reset = 1'b1;
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    exp_q.delete();
    halt_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("no_done_after_reset", {31'd0, ifc.done}, 32'd0);
    end
    $display("xfer aborted by reset at byte 37");

    trigger(8'h02, 1'b1);
    wait_done();
    $display("xfer page=02 after reset complete");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine behind CPU register $4014; sits directly upstream of the PPU's OAMDATA port.
- A write of page byte P halts the CPU, reads CPU-bus addresses $P00..$PFF, and writes each byte to the PPU register interface at index 4 (OAMDATA).
- Runs one step per clk, where one clk equals one CPU cycle.

Parameters:
- NUM_BYTES, 256: bytes per transfer; must be a power of two, at most 256.
- OAM_REG, 3'd4: PPU register index driven on ppu_addr during writes.

Ports:
- clk  in  1  system clock; one CPU cycle per edge.
- reset  in  1  asynchronous, active-high reset.
- dma_sel  in  1  decoded CPU write strobe to $4014, one cycle.
- dma_page  in  8  CPU write data (source page), valid with dma_sel.
- bus_addr  out  16  CPU-bus read address while DMA owns the bus.
- bus_rden  out  1  CPU-bus read enable.
- bus_data_in  in  8  CPU-bus read data, valid the cycle after bus_rden (registered memory).
- ppu_addr  out  3  PPU register index.
- ppu_data_out  out  8  data to PPU.
- ppu_wren  out  1  PPU register write strobe.
- cpu_halt  out  1  stalls the CPU and hands it the bus while high.
- done  out  1  one-cycle pulse on transfer completion.

Behaviour:
- Reset values:
  - State is IDLE; parity=0; idx=0; page_q=0.
  - All outputs are 0, including bus_addr=16'h0000 and ppu_addr=3'd0.
- Parity: a 1-bit register that toggles every clk and never stops, including while IDLE. 0 means even.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - On dma_sel: latch page_q<=dma_page and idx<=0, then go to HALT.
  - dma_sel in any other state is ignored; page_q does not change.
- HALT:
  - Lasts one cycle with cpu_halt=1.
  - If parity is currently 0, go to ALIGN; otherwise go to READ.
  - As a result, READ always starts on an even cycle.
- ALIGN: lasts one cycle with cpu_halt=1; then go to READ.
- READ:
  - Drives bus_addr={page_q, idx} and bus_rden=1.
  - Always goes to WRITE next.
- WRITE:
  - Drives ppu_wren=1, ppu_addr=OAM_REG and ppu_data_out=bus_data_in (combinational pass-through).
  - If idx==NUM_BYTES-1: go to IDLE and set done<=1 for the next cycle only.
  - Otherwise: idx<=idx+1 and go to READ.
- cpu_halt is 1 in every non-IDLE state and drops on the cycle done is high.
- Outputs outside their own state:
  - bus_addr, bus_rden, ppu_addr, ppu_data_out and ppu_wren are 0 outside READ/WRITE respectively.
  - bus_addr is 0 outside READ.
- Total halt length:
  - Trigger sampled on an even cycle: 1 + 2×NUM_BYTES = 513 cycles.
  - Trigger sampled on an odd cycle: 514 cycles (ALIGN inserted).
- idx is 8 bits.
  - With NUM_BYTES=256, the terminal compare at 8'hFF prevents wrap; bus_addr never leaves page P.
- dma_sel in the same cycle that done is high: accepted, since the state is IDLE. A new HALT begins next cycle and cpu_halt re-asserts after a single low cycle.
- Reset mid-transfer:
  - Outputs clear immediately (asynchronous); the state returns to IDLE.
  - No done pulse; the partially written OAM is left as is.
- Exactly NUM_BYTES ppu_wren pulses per transfer.
- ppu_wren and bus_rden are never high in the same cycle.

Test Plan:
- Reset, then idle for 10 cycles -> all outputs 0, no ppu_wren, cpu_halt=0.
- Memory preloaded so $0200+i holds i^8'hA5; dma_sel with dma_page=8'h02 on an even cycle:
  - cpu_halt high for exactly 513 cycles.
  - 256 ppu_wren pulses, each with ppu_addr=4 and data i^8'hA5 in order.
  - done pulses once, on the cycle cpu_halt falls.
- Same transfer triggered on an odd cycle -> 514 halt cycles; the first bus_rden lands on an even cycle (parity=0).
- dma_sel with page 8'h07 asserted again at transfer byte 100 -> ignored; all bus_addr values stay in 16'h0200-16'h02FF; still 256 writes.
- Back-to-back: dma_sel with page 8'h03 coincident with done -> second transfer starts; cpu_halt low for exactly 1 cycle between transfers; reads from $0300.
- reset asserted at byte 37 during WRITE -> all outputs 0 asynchronously; no done pulse; a subsequent trigger performs a full 256-byte transfer from idx 0.
